// File: rtl/wb_regfile.sv
// Write-back select, 32x32 architectural register file and retire counter of the MIPS pipeline.
// Optional write-through read bypass: define WB_REGFILE_BYPASS_EN.
module wb_regfile #(
    parameter int DATA_W = 32,
    parameter int NREG   = 32,
    parameter int CNT_W  = 32,
    parameter int AW     = $clog2(NREG)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [DATA_W-1:0] WB_c,
    input  logic [DATA_W-1:0] WB_data_read,
    input  logic [DATA_W-1:0] WB_pc,
    input  logic [1:0]        WB_s_data_write,
    input  logic [AW-1:0]     WB_num_write,
    input  logic              WB_reg_write,
    input  logic [AW-1:0]     num_read1,
    input  logic [AW-1:0]     num_read2,
    output logic [DATA_W-1:0] data_read1,
    output logic [DATA_W-1:0] data_read2,
    output logic [DATA_W-1:0] wb_data,
    output logic [CNT_W-1:0]  retire_count
);

    logic [DATA_W-1:0] regs [1:NREG-1];
    logic              wr_fire;
    logic              retire;

    always_comb begin
        wb_data = WB_c;
        case (WB_s_data_write)
            2'b01:   wb_data = WB_data_read;
            2'b10:   wb_data = WB_pc + DATA_W'(4);
            default: wb_data = WB_c;
        endcase
    end

    assign wr_fire = reset && WB_reg_write && (WB_num_write != '0);
    // A zero PC marks a bubble injected by MEM/WB reset or flush.
    assign retire  = WB_pc != '0;

    always_ff @(posedge clock) begin
        if (!reset) begin
            for (int i = 1; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_fire) begin
            regs[WB_num_write] <= wb_data;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            retire_count <= '0;
        end else if (retire) begin
            retire_count <= retire_count + CNT_W'(1);
        end
    end

    // Reads are forced to zero while reset is held so no stale value escapes before the clearing edge.
    always_comb begin
        data_read1 = '0;
        if (reset && (num_read1 != '0)) begin
            data_read1 = regs[num_read1];
`ifdef WB_REGFILE_BYPASS_EN
            if (wr_fire && (num_read1 == WB_num_write)) begin
                data_read1 = wb_data;
            end
`endif
        end
    end

    always_comb begin
        data_read2 = '0;
        if (reset && (num_read2 != '0)) begin
            data_read2 = regs[num_read2];
`ifdef WB_REGFILE_BYPASS_EN
            if (wr_fire && (num_read2 == WB_num_write)) begin
                data_read2 = wb_data;
            end
`endif
        end
    end

endmodule

// File: tb/tb_wb_regfile.sv
// Directed-vector bench for wb_regfile: write-back select, register writes/reads, reset and retire counting.
module tb_wb_regfile;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] WB_c, WB_data_read, WB_pc;
    logic [1:0]  WB_s_data_write;
    logic [4:0]  WB_num_write;
    logic        WB_reg_write;
    logic [4:0]  num_read1, num_read2;
    logic [31:0] data_read1, data_read2, wb_data, retire_count;

    int vectors = 0;
    int miscompares = 0;

    wb_regfile dut (
        .clock           (clock),
        .reset           (reset),
        .WB_c            (WB_c),
        .WB_data_read    (WB_data_read),
        .WB_pc           (WB_pc),
        .WB_s_data_write (WB_s_data_write),
        .WB_num_write    (WB_num_write),
        .WB_reg_write    (WB_reg_write),
        .num_read1       (num_read1),
        .num_read2       (num_read2),
        .data_read1      (data_read1),
        .data_read2      (data_read2),
        .wb_data         (wb_data),
        .retire_count    (retire_count)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge; inputs then change well away from it.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic [1:0] sel, input logic [31:0] c, input logic [31:0] ld,
                         input logic [31:0] pc, input logic [4:0] rd, input logic we);
        WB_s_data_write = sel;
        WB_c            = c;
        WB_data_read    = ld;
        WB_pc           = pc;
        WB_num_write    = rd;
        WB_reg_write    = we;
    endtask

    task automatic bubble();
        drive(2'b00, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0);
    endtask

    initial begin
        reset = 1'b0;
        num_read1 = 5'd0;
        num_read2 = 5'd0;
        bubble();
        step();
        step();

        // Preload r1/r2, then reset must clear them and the counter
        reset = 1'b1;
        drive(2'b00, 32'h11, 32'h0, 32'h0040_0000, 5'd1, 1'b1);
        step();
        drive(2'b00, 32'h22, 32'h0, 32'h0040_0004, 5'd2, 1'b1);
        step();
        bubble();
        num_read1 = 5'd1;
        num_read2 = 5'd2;
        #1;
        check("preload_r1", data_read1, 32'h11);
        check("preload_r2", data_read2, 32'h22);
        check("preload_cnt", retire_count, 32'd2);
        reset = 1'b0;
        #1;
        check("rst_held_rd1", data_read1, 32'h0);
        step();
        check("rst_rd1", data_read1, 32'h0);
        check("rst_rd2", data_read2, 32'h0);
        check("rst_cnt", retire_count, 32'h0);
        reset = 1'b1;
        #1;
        check("post_rst_r1", data_read1, 32'h0);
        check("post_rst_r2", data_read2, 32'h0);

        // Write-back select, combinational
        drive(2'b00, 32'hCAFE_0001, 32'hBEEF_0002, 32'h0000_1000, 5'd0, 1'b0);
        #1; check("sel00", wb_data, 32'hCAFE_0001);
        WB_s_data_write = 2'b01;
        #1; check("sel01", wb_data, 32'hBEEF_0002);
        WB_s_data_write = 2'b10;
        #1; check("sel10", wb_data, 32'h0000_1004);
        WB_s_data_write = 2'b11;
        #1; check("sel11", wb_data, 32'hCAFE_0001);
        WB_s_data_write = 2'b10;
        WB_pc = 32'hFFFF_FFFC;
        #1; check("sel10_wrap", wb_data, 32'h0);
        bubble();
        step();

        // ALU write to r5
        drive(2'b00, 32'h1234, 32'h0, 32'h0040_0000, 5'd5, 1'b1);
        step();
        bubble();
        num_read1 = 5'd5;
        #1;
        check("r5_alu", data_read1, 32'h1234);
        check("cnt_1", retire_count, 32'd1);

        // Load to r7, link to r31
        drive(2'b01, 32'h5555, 32'hDEAD_BEEF, 32'h0040_0004, 5'd7, 1'b1);
        step();
        drive(2'b10, 32'h6666, 32'h0, 32'h0040_0010, 5'd31, 1'b1);
        step();
        bubble();
        num_read1 = 5'd7;
        num_read2 = 5'd31;
        #1;
        check("r7_load", data_read1, 32'hDEAD_BEEF);
        check("r31_link", data_read2, 32'h0040_0014);
        check("cnt_3", retire_count, 32'd3);

        // Write to $0 is discarded; retiring without a write still counts
        drive(2'b00, 32'hFFFF_FFFF, 32'h0, 32'h0040_0020, 5'd0, 1'b1);
        step();
        drive(2'b00, 32'h9999, 32'h0, 32'h0040_0024, 5'd5, 1'b0);
        step();
        bubble();
        num_read1 = 5'd5;
        num_read2 = 5'd0;
        #1;
        check("r0_zero", data_read2, 32'h0);
        check("r5_no_we", data_read1, 32'h1234);
        check("cnt_5", retire_count, 32'd5);

        // Same-cycle write and read of r9
        drive(2'b00, 32'hA5A5_A5A5, 32'h0, 32'h0040_0028, 5'd9, 1'b1);
        num_read1 = 5'd9;
        num_read2 = 5'd9;
        #1;
`ifdef WB_REGFILE_BYPASS_EN
        check("r9_same_cycle", data_read1, 32'hA5A5_A5A5);
`else
        check("r9_same_cycle", data_read1, 32'h0);
`endif
        check("r9_ports_agree", data_read2, data_read1);
        step();
        bubble();
        #1;
        check("r9_next_rd1", data_read1, 32'hA5A5_A5A5);
        check("r9_next_rd2", data_read2, 32'hA5A5_A5A5);
        check("cnt_6", retire_count, 32'd6);

        // Reset coincident with a write to r3
        reset = 1'b0;
        drive(2'b00, 32'h77, 32'h0, 32'h0040_0030, 5'd3, 1'b1);
        num_read1 = 5'd3;
        num_read2 = 5'd9;
        #1;
        check("rst_wb_data", wb_data, 32'h77);
        check("rst_held_rd2", data_read2, 32'h0);
        step();
        reset = 1'b1;
        bubble();
        #1;
        check("r3_discarded", data_read1, 32'h0);
        check("r9_cleared", data_read2, 32'h0);
        check("cnt_after_rst", retire_count, 32'h0);
        step();
        check("bubble_cnt", retire_count, 32'h0);
        drive(2'b00, 32'h0, 32'h0, 32'h0040_0034, 5'd0, 1'b0);
        step();
        bubble();
        step();
        check("cnt_after_bubble", retire_count, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
